// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC16 dot-product sequencer.
//   - state_e   : sequencer FSM states
//   - OpW/AccW  : MAC16 operand and accumulator widths
//   - SatMax/Min: signed 16-bit saturation limits, held as 32-bit values
package mac_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned OpW  = 16;
  localparam int unsigned AccW = 32;

  localparam logic signed [AccW-1:0] SatMax = 32'sh0000_7FFF;
  localparam logic signed [AccW-1:0] SatMin = 32'shFFFF_8000;

endpackage

// File: rtl/mac_res_scale.sv
// Result scaling for the dot-product sequencer (purely combinational).
//   acc : raw MAC16 accumulator value (two's complement)
//   res : acc arithmetically shifted right by SHIFT, sign-extended to AccW bits
// Build option MAC_DOT_SEQ_SAT16_EN: when defined, the shifted value is clamped to the
// signed 16-bit range (0x00007FFF / 0xFFFF8000) before sign extension. When undefined,
// no clamp logic exists at all.
module mac_res_scale
  import mac_seq_pkg::*;
#(
  parameter int unsigned SHIFT = 15
) (
  input  logic [AccW-1:0] acc,
  output logic [AccW-1:0] res
);

  logic signed [AccW-1:0] shifted;

  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
`ifdef MAC_DOT_SEQ_SAT16_EN
    if (shifted > SatMax) begin
      res = $unsigned(SatMax);
    end else if (shifted < SatMin) begin
      res = $unsigned(SatMin);
    end else begin
      res = $unsigned(shifted);
    end
`else
    res = $unsigned(shifted);
`endif
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for one MAC16 slice: sum(coef[i] * samp[i]), i = 0 .. len-1.
// Walks both synchronous-read RAMs with a shared address, gates the returning data into
// the MAC16 operand pins, then scales the accumulator and offers it on a valid/ready port.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   start, len            request (accepted only while busy=0); len sampled on acceptance
//   busy                  high from acceptance until the result handshake completes
//   coef_addr, samp_addr  RAM read addresses (same value on both)
//   coef_data, samp_data  RAM read data, MEM_LAT cycles after the address
//   mac_a, mac_b          MAC16 operands (zero for pipeline slots carrying no term)
//   mac_ce, mac_orst      MAC16 clock enable and accumulator reset
//   mac_o                 MAC16 accumulator output, MAC_LAT cycles after the operands
//   res_data, res_valid   scaled result and its valid
//   res_ready             consumer ready
//
// Build option MAC_DOT_SEQ_SAT16_EN: saturate the scaled result to signed 16 bits
// (implemented in mac_res_scale).
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned SHIFT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] samp_addr,
  input  logic [OpW-1:0]    coef_data,
  input  logic [OpW-1:0]    samp_data,
  output logic [OpW-1:0]    mac_a,
  output logic [OpW-1:0]    mac_b,
  output logic              mac_ce,
  output logic              mac_orst,
  input  logic [AccW-1:0]   mac_o,
  output logic [AccW-1:0]   res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  // Cycles between the last issued address and the accumulator holding the full sum.
  localparam int unsigned DrainCyc = MEM_LAT + MAC_LAT;
  localparam int unsigned DrainW   = (DrainCyc > 1) ? $clog2(DrainCyc) : 1;

  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCyc - 1);
  localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LenOne    = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic [MEM_LAT-1:0]  vld_q, vld_d;
  logic [AccW-1:0]     res_q, res_d;
  logic [AccW-1:0]     scaled;

  logic issue;
  logic last_addr;
  logic drain_done;
  logic data_vld;

  assign issue      = (state_q == StIssue);
  // len_q >= 1 whenever ISSUE is entered, so len_q - 1 never underflows here.
  assign last_addr  = ({1'b0, addr_q} == (len_q - LenOne));
  assign drain_done = (drain_q == DrainLast);
  // Valid bit that has travelled alongside the address through the RAM read latency.
  assign data_vld   = vld_q[MEM_LAT-1];

  mac_res_scale #(
    .SHIFT (SHIFT)
  ) u_scale (
    .acc (mac_o),
    .res (scaled)
  );

  // ---------------------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (last_addr) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      drain_q <= '0;
      vld_q   <= '0;
      res_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    drain_d = drain_q;
    res_d   = res_q;

    vld_d[0] = issue;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          drain_d = '0;
          // A zero-length product completes immediately with a zero result.
          res_d   = '0;
        end
      end
      StIssue: begin
        // Hold on the last address so len == 2**ADDR_W never wraps back to 0.
        if (!last_addr) begin
          addr_d = addr_q + AddrOne;
        end
      end
      StDrain: begin
        drain_d = drain_q + DrainOne;
        if (drain_done) begin
          res_d = scaled;
        end
      end
      StDone: begin
        // Park the address at 0 between runs so idle periods show no address movement.
        if (res_ready) begin
          addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b1;
    mac_ce    = 1'b0;
    mac_orst  = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        mac_orst = 1'b1;
      end
      StIssue,
      StDrain: begin
        mac_ce = 1'b1;
      end
      StDone: begin
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign coef_addr = addr_q;
  assign samp_addr = addr_q;
  // Empty pipeline slots feed zeros so they add nothing to the accumulator.
  assign mac_a     = data_vld ? coef_data : '0;
  assign mac_b     = data_vld ? samp_data : '0;
  assign res_data  = res_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq. Two instances share all inputs: u_dut0 with SHIFT=0 (raw sums)
// and u_dut15 with SHIFT=15 (Q15 scaling). Both see the same RAM and MAC16 model, which
// is driven from u_dut0's pins.
module tb_mac_dot_seq;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          res_ready;
  logic [15:0]   coef_data, samp_data;
  logic [31:0]   mac_o;

  logic          busy, mac_ce, mac_orst, res_valid;
  logic [AW-1:0] coef_addr, samp_addr;
  logic [15:0]   mac_a, mac_b;
  logic [31:0]   res_data;

  logic          busy2, mac_ce2, mac_orst2, res_valid2;
  logic [AW-1:0] coef_addr2, samp_addr2;
  logic [15:0]   mac_a2, mac_b2;
  logic [31:0]   res_data2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(.ADDR_W(AW), .MEM_LAT(1), .MAC_LAT(2), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .coef_addr(coef_addr), .samp_addr(samp_addr), .coef_data(coef_data),
    .samp_data(samp_data), .mac_a(mac_a), .mac_b(mac_b), .mac_ce(mac_ce),
    .mac_orst(mac_orst), .mac_o(mac_o), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  mac_dot_seq #(.ADDR_W(AW), .MEM_LAT(1), .MAC_LAT(2), .SHIFT(15)) u_dut15 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy2),
    .coef_addr(coef_addr2), .samp_addr(samp_addr2), .coef_data(coef_data),
    .samp_data(samp_data), .mac_a(mac_a2), .mac_b(mac_b2), .mac_ce(mac_ce2),
    .mac_orst(mac_orst2), .mac_o(mac_o), .res_data(res_data2), .res_valid(res_valid2),
    .res_ready(res_ready)
  );

  // Synchronous-read RAMs, one cycle latency.
  logic [15:0] coef_mem [256];
  logic [15:0] samp_mem [256];
  always @(posedge clk) begin
    coef_data <= coef_mem[coef_addr];
    samp_data <= samp_mem[samp_addr];
  end

  // MAC16 model: input register then accumulator register; orst clears the pipeline.
  logic signed [15:0] a_q, b_q;
  logic signed [31:0] acc;
  always @(posedge clk) begin
    if (mac_orst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (mac_ce) begin
      a_q <= mac_a;
      b_q <= mac_b;
      acc <= acc + a_q * b_q;
    end
  end
  assign mac_o = acc;

  int ce_cnt;
  always @(posedge clk) begin
    if (rst) ce_cnt <= 0;
    else     ce_cnt <= ce_cnt + int'(mac_ce);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic start_run(input int n);
    start = 1'b1;
    len   = (AW + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  typedef struct {
    string             name;
    int                n;
    logic [3:0][15:0]  c;
    logic [3:0][15:0]  s;
    logic [31:0]       exp0;
    logic [31:0]       exp15;
    int                lat;
  } vec_t;

  // 0x7FFF^2 * 2 = 0x7FFE0002 stays positive; 0x8000*0x7FFF * 2 = 0x80010000.
`ifdef MAC_DOT_SEQ_SAT16_EN
  localparam logic [31:0] PosRaw = 32'h0000_7FFF, PosQ15 = 32'h0000_7FFF;
  localparam logic [31:0] NegRaw = 32'hFFFF_8000, NegQ15 = 32'hFFFF_8000;
`else
  localparam logic [31:0] PosRaw = 32'h7FFE_0002, PosQ15 = 32'h0000_FFFC;
  localparam logic [31:0] NegRaw = 32'h8001_0000, NegQ15 = 32'hFFFF_0002;
`endif

  vec_t vecs [6];

  initial begin
    int lat, ce0, sticky;
    logic [31:0] r0, r15;

    vecs[0] = '{"len1",    1, {16'd0, 16'd0, 16'd0, 16'd5},
                              {16'd0, 16'd0, 16'd0, 16'd3}, 32'd15, 32'd0, 5};
    vecs[1] = '{"len4neg", 4, {16'd4, 16'd3, 16'd2, 16'd1},
                              {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                              32'hFFFF_FFF6, 32'hFFFF_FFFF, 8};
    vecs[2] = '{"len0",    0, '0, '0, 32'd0, 32'd0, 1};
    vecs[3] = '{"len3mix", 3, {16'd0, 16'd300, 16'hFF38, 16'd100},
                              {16'd0, 16'hFFF7, 16'd8, 16'd7},
                              32'hFFFF_F1F0, 32'hFFFF_FFFF, 7};
    vecs[4] = '{"pos_big", 2, {16'd0, 16'd0, 16'h7FFF, 16'h7FFF},
                              {16'd0, 16'd0, 16'h7FFF, 16'h7FFF}, PosRaw, PosQ15, 6};
    vecs[5] = '{"neg_big", 2, {16'd0, 16'd0, 16'h8000, 16'h8000},
                              {16'd0, 16'd0, 16'h7FFF, 16'h7FFF}, NegRaw, NegQ15, 6};

    for (int i = 0; i < 256; i++) begin
      coef_mem[i] = '0;
      samp_mem[i] = '0;
    end
    rst = 1'b1; start = 1'b0; len = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_orst",      {31'd0, mac_orst},  32'd1);
    chk("rst_ce",        {31'd0, mac_ce},    32'd0);
    chk("rst_valid",     {31'd0, res_valid}, 32'd0);
    chk("rst_addr",      {24'd0, coef_addr}, 32'd0);
    chk("rst_mac_a",     {16'd0, mac_a},     32'd0);
    chk("rst_res_data",  res_data,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven single runs.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        coef_mem[i] = vecs[v].c[i];
        samp_mem[i] = vecs[v].s[i];
      end
      ce0 = ce_cnt;
      start_run(vecs[v].n);
      wait_valid(lat);
      r0  = res_data;
      r15 = res_data2;
      ack();
      chk({vecs[v].name, "_res0"},  r0,  vecs[v].exp0);
      chk({vecs[v].name, "_res15"}, r15, vecs[v].exp15);
      chk({vecs[v].name, "_lat"},   32'(lat), 32'(vecs[v].lat));
      chk({vecs[v].name, "_ce"},    32'(ce_cnt - ce0),
          32'((vecs[v].n == 0) ? 0 : vecs[v].n + 3));
      chk({vecs[v].name, "_idle"},  {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end

    // Back-pressure: result held for 10 cycles, a start in the middle is ignored.
    coef_mem[0] = 16'd2; coef_mem[1] = 16'd3;
    samp_mem[0] = 16'd4; samp_mem[1] = 16'd5;
    start_run(2);
    wait_valid(lat);
    chk("stall_lat", 32'(lat), 32'd6);
    sticky = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1;
        len   = 9'd1;
      end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (!res_valid || res_data !== 32'd23 || !busy) sticky++;
    end
    chk("stall_stable", 32'(sticky), 32'd0);
    chk("stall_data",   res_data,    32'd23);
    ack();
    chk("stall_idle", {31'd0, busy}, 32'd0);
    sticky = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy || res_valid) sticky++;
    end
    chk("stall_no_rerun", 32'(sticky), 32'd0);

    // Ready already high when valid rises; a start in the DONE cycle waits one cycle.
    coef_mem[0] = 16'd5; samp_mem[0] = 16'd3;
    res_ready = 1'b1;
    start_run(1);
    wait_valid(lat);
    chk("rdyhi_lat",  32'(lat), 32'd5);
    chk("rdyhi_data", res_data, 32'd15);
    start = 1'b1; len = 9'd1;
    @(posedge clk); #1;
    chk("rdyhi_done_busy",  {31'd0, busy},      32'd0);
    chk("rdyhi_done_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("rdyhi_restart_busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    chk("rdyhi_restart_lat",  32'(lat), 32'd5);
    chk("rdyhi_restart_data", res_data, 32'd15);
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("rdyhi_restart_clear", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset in ISSUE after addresses 0..2, while address 3 is on the bus.
    for (int i = 0; i < 5; i++) begin
      coef_mem[i] = 16'd9;
      samp_mem[i] = 16'd9;
    end
    start_run(5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_addr", {24'd0, coef_addr}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_orst",  {31'd0, mac_orst},  32'd1);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    sticky = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (res_valid) sticky++;
    end
    chk("abort_no_result", 32'(sticky), 32'd0);
    coef_mem[0] = 16'd2; coef_mem[1] = 16'd3;
    samp_mem[0] = 16'd4; samp_mem[1] = 16'd5;
    start_run(2);
    wait_valid(lat);
    chk("abort_rerun_lat",  32'(lat), 32'd6);
    chk("abort_rerun_data", res_data, 32'd23);
    ack();

    // Full-depth run: len = 256, address holds at 255 instead of wrapping.
    for (int i = 0; i < 256; i++) begin
      coef_mem[i] = 16'd1;
      samp_mem[i] = 16'd1;
    end
    start_run(256);
    wait_valid(lat);
    chk("full_lat",    32'(lat),           32'd260);
    chk("full_addr",   {24'd0, coef_addr}, 32'd255);
    chk("full_res0",   res_data,           32'd256);
    chk("full_res15",  res_data2,          32'd0);
    ack();
    chk("full_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
